mult_exhaustive_checker: RTL and testbench
==========================================

# mult_exhaustive_checker

Sequential sweep-and-score stage for the RL-generated small multipliers. Drives every operand pair {A,B} into a combinational candidate multiplier, one per clock. Compares the returned product against the exact product and accumulates error statistics. Sits directly around the candidate: upstream it feeds A/B, downstream it consumes P, and it reports a score used to reward or correct the candidate.

## Interface
- N, default 2: operand width of the candidate multiplier (product width 2N).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a full sweep; sampled only in IDLE.
- dut_a  output  N  operand A driven to the candidate.
- dut_b  output  N  operand B driven to the candidate.
- dut_p  input  2N  product returned by the candidate (combinational, same cycle).
- busy  output  1  high while sweeping.
- done  output  1  one-cycle pulse when results are final.
- err_count  output  2N+1  number of vectors with dut_p != dut_a*dut_b.
- abs_err_sum  output  4N  sum of |dut_p - exact| over all vectors.
- max_abs_err  output  2N  largest single |dut_p - exact|.
- first_err_valid  output  1  at least one mismatch captured.
- first_err_a / first_err_b  output  N  operands of the first mismatching vector.
- first_err_p  output  2N  dut_p of that vector.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: busy=0. On start=1, clear all result registers and set vector index idx=0. Go to SCAN.
- SCAN: idx is a 2N-bit counter. dut_a=idx[2N-1:N], dut_b=idx[N-1:0], so A is the major and B the minor order. Each cycle, exact = dut_a*dut_b, computed 2N bits wide and unsigned, is compared with dut_p; results are registered at the clock edge.
  - On mismatch: err_count++, abs_err_sum += |dut_p - exact|, computed unsigned with no wrap. max_abs_err = max(current, |diff|).
  - On the first mismatch only: latch first_err_a/b/p and set first_err_valid.
  - When idx = 2^(2N)-1 the vector is scored, idx wraps to 0, and the FSM goes to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- While not in SCAN, dut_a and dut_b are 0.
- start is ignored in SCAN and DONE. Holding start high re-triggers a sweep from the first IDLE cycle after DONE.
- All result outputs hold their values from DONE until the next accepted start, which clears them.
- Width rules: err_count reaches at most 2^(2N), hence 2N+1 bits. abs_err_sum is below 2^(4N). No saturation is required.

## Timing
- Reset (asynchronous, any state): state=IDLE, idx=0, all outputs 0, including first_err_valid, done and busy.
- Reset mid-SCAN aborts immediately. Partial results are discarded (zeroed).
- start is high at edge t in IDLE. busy is 1 and vector 0 is driven during cycle t+1. Vector k is driven in cycle t+1+k.
- The last vector is driven in cycle t+2^(2N). done=1 in cycle t+1+2^(2N). The FSM is back in IDLE at t+2+2^(2N).
- Total latency from start to done is 2^(2N)+1 cycles: 17 for N=2, 257 for N=4.
- Results are stable and final in the done cycle.

## Test plan
- Exact multiplier model, N=2, one start pulse:
  - done exactly 17 cycles after start.
  - err_count=0, abs_err_sum=0, max_abs_err=0, first_err_valid=0.
- Model with P[0] stuck at 0, N=2:
  - err_count=4, abs_err_sum=4, max_abs_err=1.
  - first_err = (a=1, b=1, p=0).
- Model returning P=0 for all inputs, N=2:
  - err_count=9, abs_err_sum=36, max_abs_err=9.
  - first_err = (1, 1, 0).
- Assert rst_n low during cycle 6 of a sweep:
  - All outputs go to 0 asynchronously and the FSM returns to IDLE.
  - A new start with the exact model yields a clean 17-cycle sweep with zero errors.
- Hold start high continuously, P[0] stuck-at-0 model:
  - done pulses every 18 cycles.
  - Every done shows err_count=4; results are not accumulated across sweeps.
  - A start pulse during SCAN does not restart the sweep.
- N=4, exact model:
  - done 257 cycles after start with err_count=0.
  - dut_a/dut_b sequence spot-checked: cycle t+1+0x5C drives a=5, b=12.

Source files
------------

// File: rtl/mult_exhaustive_checker.sv
// Exhaustive sweep-and-score wrapper for a small combinational multiplier.
// Drives every {A,B} pair, one per clock, and accumulates error statistics.
//
// Ports:
//   clk, rst_n        rising-edge clock, async active-low reset
//   start             request a sweep (sampled in IDLE only)
//   dut_a, dut_b      operands to candidate (0 outside SCAN)
//   dut_p             candidate product (combinational, same cycle)
//   busy, done        sweeping / one-cycle results-final pulse
//   err_count         mismatching vector count
//   abs_err_sum       sum of |dut_p - exact|
//   max_abs_err       largest |dut_p - exact|
//   first_err_*       first mismatching vector and its product
module mult_exhaustive_checker #(
   parameter int N = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   output logic [N-1:0]   dut_a,
   output logic [N-1:0]   dut_b,
   input  logic [2*N-1:0] dut_p,
   output logic           busy,
   output logic           done,
   output logic [2*N:0]   err_count,
   output logic [4*N-1:0] abs_err_sum,
   output logic [2*N-1:0] max_abs_err,
   output logic           first_err_valid,
   output logic [N-1:0]   first_err_a,
   output logic [N-1:0]   first_err_b,
   output logic [2*N-1:0] first_err_p
);

   localparam int W = 2 * N;
   localparam logic [W-1:0] LAST_IDX = '1;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [W-1:0]   r_idx;
   logic [W:0]     r_err_count;
   logic [4*N-1:0] r_abs_sum;
   logic [W-1:0]   r_max_err;
   logic           r_fe_valid;
   logic [N-1:0]   r_fe_a;
   logic [N-1:0]   r_fe_b;
   logic [W-1:0]   r_fe_p;

   logic           w_scan;
   logic           w_accept;
   logic           w_last;
   logic [W-1:0]   w_exact;
   logic [W-1:0]   w_diff;
   logic           w_mis;

   assign w_scan   = (r_state == SCAN);
   assign w_accept = (r_state == IDLE) && start;
   assign w_last   = (r_idx == LAST_IDX);

   // A is the major index, B the minor one.
   assign dut_a = w_scan ? r_idx[W-1:N] : '0;
   assign dut_b = w_scan ? r_idx[N-1:0] : '0;

   // Zero-extend before multiplying so the product keeps all 2N bits.
   assign w_exact = {{N{1'b0}}, dut_a} * {{N{1'b0}}, dut_b};

   // Magnitude of the error without wrap-around.
   assign w_diff = (dut_p >= w_exact) ? (dut_p - w_exact)
                                      : (w_exact - dut_p);

   assign w_mis = w_scan && (dut_p != w_exact);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (start) w_next = SCAN;
         SCAN:    if (w_last) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx       <= '0;
         r_err_count <= '0;
         r_abs_sum   <= '0;
         r_max_err   <= '0;
         r_fe_valid  <= 1'b0;
         r_fe_a      <= '0;
         r_fe_b      <= '0;
         r_fe_p      <= '0;
      end else if (w_accept) begin
         r_idx       <= '0;
         r_err_count <= '0;
         r_abs_sum   <= '0;
         r_max_err   <= '0;
         r_fe_valid  <= 1'b0;
         r_fe_a      <= '0;
         r_fe_b      <= '0;
         r_fe_p      <= '0;
      end else if (w_scan) begin
         // Wraps to 0 after the last vector.
         r_idx <= r_idx + W'(1);
         if (w_mis) begin
            r_err_count <= r_err_count + (W+1)'(1);
            r_abs_sum   <= r_abs_sum + {{W{1'b0}}, w_diff};
            if (w_diff > r_max_err) begin
               r_max_err <= w_diff;
            end
            if (!r_fe_valid) begin
               r_fe_valid <= 1'b1;
               r_fe_a     <= dut_a;
               r_fe_b     <= dut_b;
               r_fe_p     <= dut_p;
            end
         end
      end
   end

   assign busy            = w_scan;
   assign done            = (r_state == DONE);
   assign err_count       = r_err_count;
   assign abs_err_sum     = r_abs_sum;
   assign max_abs_err     = r_max_err;
   assign first_err_valid = r_fe_valid;
   assign first_err_a     = r_fe_a;
   assign first_err_b     = r_fe_b;
   assign first_err_p     = r_fe_p;

endmodule

// File: tb/tb_mult_exhaustive_checker.sv
// Directed bench for mult_exhaustive_checker (N=2 and N=4 instances).
// Candidate models: exact, P[0] stuck at 0, constant zero.
module tb_mult_exhaustive_checker;

   logic clk;
   logic rst_n;
   logic st2;
   logic st4;
   logic [1:0] mode;

   logic [1:0] a2, b2, fa2, fb2;
   logic [3:0] p2, max2, fp2;
   logic [4:0] err2;
   logic [7:0] sum2;
   logic       busy2, done2, fv2;

   logic [3:0]  a4, b4, fa4, fb4;
   logic [7:0]  p4, max4, fp4;
   logic [8:0]  err4;
   logic [15:0] sum4;
   logic        busy4, done4, fv4;

   int total = 0;
   int bad   = 0;
   int lat;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      p2 = 4'd0;
      case (mode)
         2'd0:    p2 = {2'b00, a2} * {2'b00, b2};
         2'd1:    p2 = ({2'b00, a2} * {2'b00, b2}) & 4'b1110;
         default: p2 = 4'd0;
      endcase
   end

   assign p4 = {4'b0000, a4} * {4'b0000, b4};

   mult_exhaustive_checker #(.N(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(st2),
      .dut_a(a2), .dut_b(b2), .dut_p(p2),
      .busy(busy2), .done(done2),
      .err_count(err2), .abs_err_sum(sum2),
      .max_abs_err(max2), .first_err_valid(fv2),
      .first_err_a(fa2), .first_err_b(fb2),
      .first_err_p(fp2)
   );

   mult_exhaustive_checker #(.N(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(st4),
      .dut_a(a4), .dut_b(b4), .dut_p(p4),
      .busy(busy4), .done(done4),
      .err_count(err4), .abs_err_sum(sum4),
      .max_abs_err(max4), .first_err_valid(fv4),
      .first_err_a(fa4), .first_err_b(fb4),
      .first_err_p(fp4)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts an N=2 sweep, optional extra start pulse at edge pa,
   // returns edges counted until done (0 on timeout).
   task automatic run2(input int pa, output int l);
      int c;
      c = 0;
      l = 0;
      st2 = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step();
         c++;
         if (c == 1) begin
            st2 = 1'b0;
            chk("busy_v0", {31'd0, busy2}, 32'd1);
            chk("vec0_ab", {28'd0, a2, b2}, 32'd0);
         end
         if (pa != 0 && c == pa) st2 = 1'b1;
         if (pa != 0 && c == pa + 1) st2 = 1'b0;
         if (done2) begin
            l = c;
            break;
         end
      end
      if (l == 0) chk("timeout2", 32'd0, 32'd1);
   endtask

   initial begin
      int c;
      int n;
      int prev;
      rst_n = 1'b0;
      st2   = 1'b0;
      st4   = 1'b0;
      mode  = 2'd0;
      #12;
      chk("rst_busy", {31'd0, busy2}, 32'd0);
      chk("rst_done", {31'd0, done2}, 32'd0);
      chk("rst_err", {27'd0, err2}, 32'd0);
      chk("rst_fv", {31'd0, fv2}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // exact model, plus a start pulse mid-scan that must be ignored
      mode = 2'd0;
      run2(5, lat);
      chk("ex_lat", lat, 32'd17);
      chk("ex_err", {27'd0, err2}, 32'd0);
      chk("ex_sum", {24'd0, sum2}, 32'd0);
      chk("ex_max", {28'd0, max2}, 32'd0);
      chk("ex_fv", {31'd0, fv2}, 32'd0);
      step();
      chk("ex_done1", {31'd0, done2}, 32'd0);
      chk("ex_idle_a", {30'd0, a2}, 32'd0);

      // P[0] stuck at 0
      mode = 2'd1;
      run2(0, lat);
      chk("s0_lat", lat, 32'd17);
      chk("s0_err", {27'd0, err2}, 32'd4);
      chk("s0_sum", {24'd0, sum2}, 32'd4);
      chk("s0_max", {28'd0, max2}, 32'd1);
      chk("s0_fv", {31'd0, fv2}, 32'd1);
      chk("s0_fa", {30'd0, fa2}, 32'd1);
      chk("s0_fb", {30'd0, fb2}, 32'd1);
      chk("s0_fp", {28'd0, fp2}, 32'd0);
      step();
      chk("s0_hold", {27'd0, err2}, 32'd4);

      // constant zero product
      mode = 2'd2;
      run2(0, lat);
      chk("z_lat", lat, 32'd17);
      chk("z_err", {27'd0, err2}, 32'd9);
      chk("z_sum", {24'd0, sum2}, 32'd36);
      chk("z_max", {28'd0, max2}, 32'd9);
      chk("z_fa", {30'd0, fa2}, 32'd1);
      chk("z_fb", {30'd0, fb2}, 32'd1);
      chk("z_fp", {28'd0, fp2}, 32'd0);
      step();

      // reset in mid-sweep: vectors 0..6 scored, (1,1),(1,2) wrong
      mode = 2'd2;
      st2  = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (i == 1) st2 = 1'b0;
      end
      chk("mid_err", {27'd0, err2}, 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_busy", {31'd0, busy2}, 32'd0);
      chk("ar_err", {27'd0, err2}, 32'd0);
      chk("ar_sum", {24'd0, sum2}, 32'd0);
      chk("ar_max", {28'd0, max2}, 32'd0);
      chk("ar_fv", {31'd0, fv2}, 32'd0);
      chk("ar_ab", {28'd0, a2, b2}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mode  = 2'd0;
      step();
      chk("ar_idle", {31'd0, busy2}, 32'd0);
      run2(0, lat);
      chk("ar_lat", lat, 32'd17);
      chk("ar_err2", {27'd0, err2}, 32'd0);
      step();

      // start held high: repeated, non-accumulating sweeps
      mode = 2'd1;
      st2  = 1'b1;
      n    = 0;
      prev = 0;
      for (c = 1; c <= 80; c++) begin
         step();
         if (c == 60) st2 = 1'b0;
         if (done2) begin
            n++;
            if (prev != 0) chk("hold_per", c - prev, 32'd18);
            else chk("hold_first", c, 32'd17);
            chk("hold_err", {27'd0, err2}, 32'd4);
            prev = c;
         end
      end
      chk("hold_n", n, 32'd4);
      chk("hold_stop", {31'd0, busy2}, 32'd0);

      // N=4 exact sweep with spot check of vector 0x5C
      lat = 0;
      st4 = 1'b1;
      for (c = 1; c <= 400; c++) begin
         step();
         if (c == 1) st4 = 1'b0;
         if (c == 32'h5D) begin
            chk("n4_a", {28'd0, a4}, 32'd5);
            chk("n4_b", {28'd0, b4}, 32'd12);
         end
         if (done4) begin
            lat = c;
            break;
         end
      end
      chk("n4_lat", lat, 32'd257);
      chk("n4_err", {23'd0, err4}, 32'd0);
      chk("n4_fv", {31'd0, fv4}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
